// File: rtl/rob_drain_sequencer_pkg.sv
// Shared encodings for the ROB drain sequencer: DRAM commands, LoS codes, item field layout, FSM states.
package rob_drain_sequencer_pkg;

  localparam int ROW_W_DEF  = 11;
  localparam int COL_W_DEF  = 8;
  localparam int ITEM_W_DEF = 24;

  typedef enum logic [2:0] {
    CMD_NOP = 3'b000,
    CMD_ACT = 3'b001,
    CMD_RD  = 3'b010,
    CMD_WR  = 3'b011,
    CMD_PRE = 3'b100,
    CMD_RDA = 3'b101,
    CMD_WRA = 3'b110
  } cmd_e;

  localparam logic [1:0] LOS_LOAD  = 2'b01;
  localparam logic [1:0] LOS_STORE = 2'b10;

  // Item layout: [0] valid, then COL_W column bits, 2 LoS bits, 2 size bits.
  localparam int ITEM_VALID_BIT = 0;
  localparam int ITEM_COL_LSB   = 1;
  localparam int ITEM_LOS_W     = 2;
  localparam int ITEM_SIZE_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDROB,
    ST_COLLECT,
    ST_ACT,
    ST_TRCD,
    ST_COL,
    ST_PRE,
    ST_TRP
  } state_e;

endpackage

// File: rtl/rob_drain_sequencer_fifo.sv
// drain_item_fifo: DEPTH-deep synchronous FIFO, combinational head, registered count.
// Push while full is accepted only when a pop happens in the same cycle.
module drain_item_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/rob_drain_sequencer.sv
// Drains one scheduler row: ROB read, buffer items, then ACT / RD|WR per item / PRE (RDA/WRA when DRAIN_AUTO_PRE_EN).
// ACT one cycle after the first push, first column T_RCD+1 after ACT; commands hold while oCmdValid & ~iCmdReady.
module rob_drain_sequencer
  import rob_drain_sequencer_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int ITEM_W = ITEM_W_DEF,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int TMO    = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iRowReq,
  input  logic [ROW_W-1:0]  iRow,
  output logic              oRowAck,
  output logic              oROB_Rd,
  output logic [ROW_W-1:0]  oROB_Row,
  input  logic              iROB_ItemValid,
  input  logic [ITEM_W-1:0] iROB_Item,
  input  logic              iROB_ItemEnd,
  output logic              oCmdValid,
  input  logic              iCmdReady,
  output logic [2:0]        oCmd,
  output logic [ROW_W-1:0]  oCmdRow,
  output logic [COL_W-1:0]  oCmdCol,
  output logic [1:0]        oCmdSize,
  output logic              oBusy,
  output logic              oOverflow,
  output logic              oTimeout
);

  localparam int LOS_LSB  = ITEM_COL_LSB + COL_W;
  localparam int SIZE_LSB = LOS_LSB + ITEM_LOS_W;
  localparam int ENT_W    = COL_W + 3;
  localparam int TMO_W    = $clog2(TMO + 1);

  state_e             state;
  state_e             state_nxt;
  logic [ROW_W-1:0]   row_q;
  logic [3:0]         wait_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               end_seen;
  logic               overflow_q;
  logic               timeout_q;

  logic [1:0]         item_los;
  logic               item_ok;
  logic               stream_open;
  logic               push_req;
  logic               pop;
  logic               push;
  logic [ENT_W-1:0]   push_dat;
  logic [ENT_W-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [3:0]         fifo_count;
  logic               last_cmd;
  logic               unused_item_bits;

  assign item_los    = iROB_Item[LOS_LSB +: ITEM_LOS_W];
  assign item_ok     = iROB_ItemValid & iROB_Item[ITEM_VALID_BIT] &
                       ((item_los == LOS_LOAD) | (item_los == LOS_STORE));
  // The ROB stream stays open from the cycle after the read strobe until end or timeout.
  assign stream_open = (state inside {ST_COLLECT, ST_ACT, ST_TRCD, ST_COL}) & ~end_seen;
  assign push_req    = stream_open & item_ok;
  assign pop         = (state == ST_COL) & ~fifo_empty & iCmdReady;
  assign push        = push_req & (~fifo_full | pop);
  assign push_dat    = {iROB_Item[SIZE_LSB +: ITEM_SIZE_W], item_los == LOS_STORE,
                        iROB_Item[ITEM_COL_LSB +: COL_W]};
  assign unused_item_bits = ^iROB_Item[ITEM_W-1:SIZE_LSB+ITEM_SIZE_W];

  drain_item_fifo #(.W(ENT_W), .DEPTH(8)) u_fifo (
    .clk      (clk),
    .rst_n    (resetn),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef DRAIN_AUTO_PRE_EN
  logic stall_q;
  logic auto_q;
  logic last_now;

  assign last_now = (fifo_count == 4'd1) & end_seen & ~push_req;
  // A stalled column command keeps the auto-precharge choice it was first presented with.
  assign last_cmd = stall_q ? auto_q : last_now;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      stall_q <= (state == ST_COL) & ~fifo_empty & ~iCmdReady;
      auto_q  <= last_cmd;
    end
  end
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
  assign last_cmd = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    oRowAck   = 1'b0;
    oROB_Rd   = 1'b0;
    oROB_Row  = '0;
    oCmdValid = 1'b0;
    oCmd      = CMD_NOP;
    oCmdRow   = '0;
    oCmdCol   = '0;
    oCmdSize  = '0;
    case (state)
      ST_IDLE: begin
        if (iRowReq) begin
          oRowAck   = 1'b1;
          state_nxt = ST_RDROB;
        end
      end
      ST_RDROB: begin
        oROB_Rd   = 1'b1;
        oROB_Row  = row_q;
        state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (push_req || !fifo_empty) state_nxt = ST_ACT;
        else if (end_seen)           state_nxt = ST_IDLE;
      end
      ST_ACT: begin
        oCmdValid = 1'b1;
        oCmd      = CMD_ACT;
        oCmdRow   = row_q;
        if (iCmdReady) state_nxt = ST_TRCD;
      end
      ST_TRCD: begin
        if (wait_cnt == 4'(T_RCD - 1)) state_nxt = ST_COL;
      end
      ST_COL: begin
        if (!fifo_empty) begin
          oCmdValid = 1'b1;
          oCmdCol   = head[COL_W-1:0];
          oCmdSize  = head[COL_W+2:COL_W+1];
          if (head[COL_W]) oCmd = last_cmd ? CMD_WRA : CMD_WR;
          else             oCmd = last_cmd ? CMD_RDA : CMD_RD;
          if (iCmdReady && last_cmd) state_nxt = ST_TRP;
        end else if (end_seen) begin
          // Also reached with auto-precharge when the stream ended after the buffer drained.
          state_nxt = ST_PRE;
        end
      end
      ST_PRE: begin
        oCmdValid = 1'b1;
        oCmd      = CMD_PRE;
        oCmdRow   = row_q;
        if (iCmdReady) state_nxt = ST_TRP;
      end
      ST_TRP: begin
        if (wait_cnt == 4'(T_RP - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      row_q      <= '0;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      end_seen   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && iRowReq) row_q <= iRow;
      if ((state == ST_TRCD || state == ST_TRP) && state_nxt == state) wait_cnt <= wait_cnt + 1'b1;
      else                                                           wait_cnt <= '0;
      if (state == ST_RDROB) begin
        end_seen <= 1'b0;
        tmo_cnt  <= '0;
      end else if (stream_open) begin
        if (iROB_ItemEnd) begin
          end_seen <= 1'b1;
        end else if (tmo_cnt == TMO_W'(TMO - 1)) begin
          end_seen  <= 1'b1;
          timeout_q <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign oBusy     = (state != ST_IDLE);
  assign oOverflow = overflow_q;
  assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_rob_drain_sequencer.sv
// Directed bench for rob_drain_sequencer: logs every command handshake and compares against hand-built sequences.
`timescale 1ns/1ps
module tb_rob_drain_sequencer;
  import rob_drain_sequencer_pkg::*;

`ifdef DRAIN_AUTO_PRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        iRowReq;
  logic [10:0] iRow;
  logic        oRowAck;
  logic        oROB_Rd;
  logic [10:0] oROB_Row;
  logic        iROB_ItemValid;
  logic [23:0] iROB_Item;
  logic        iROB_ItemEnd;
  logic        oCmdValid;
  logic        iCmdReady;
  logic [2:0]  oCmd;
  logic [10:0] oCmdRow;
  logic [7:0]  oCmdCol;
  logic [1:0]  oCmdSize;
  logic        oBusy;
  logic        oOverflow;
  logic        oTimeout;

  always #5 clk = ~clk;

  rob_drain_sequencer dut (
    .clk            (clk),
    .resetn         (resetn),
    .iRowReq        (iRowReq),
    .iRow           (iRow),
    .oRowAck        (oRowAck),
    .oROB_Rd        (oROB_Rd),
    .oROB_Row       (oROB_Row),
    .iROB_ItemValid (iROB_ItemValid),
    .iROB_Item      (iROB_Item),
    .iROB_ItemEnd   (iROB_ItemEnd),
    .oCmdValid      (oCmdValid),
    .iCmdReady      (iCmdReady),
    .oCmd           (oCmd),
    .oCmdRow        (oCmdRow),
    .oCmdCol        (oCmdCol),
    .oCmdSize       (oCmdSize),
    .oBusy          (oBusy),
    .oOverflow      (oOverflow),
    .oTimeout       (oTimeout)
  );

  typedef struct packed {
    logic [2:0]  cmd;
    logic [10:0] row;
    logic [7:0]  col;
    logic [1:0]  size;
  } ev_t;

  ev_t  log_q[$];
  int   log_cyc[$];
  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_stall = 0;
  bit   any_valid = 1'b0;
  bit   stall_q = 1'b0;
  ev_t  prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake logger plus hold check on any command stalled in the previous cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      stall_q = 1'b0;
    end else begin
      if (oCmdValid) any_valid = 1'b1;
      if (stall_q) begin
        n_stall++;
        check("stall_hold", {oCmdValid, oCmd, oCmdRow, oCmdCol, oCmdSize}, {1'b1, prev});
      end
      if (oCmdValid && iCmdReady) begin
        log_q.push_back({oCmd, oCmdRow, oCmdCol, oCmdSize});
        log_cyc.push_back(cyc);
      end
      stall_q = oCmdValid && !iCmdReady;
      prev    = {oCmd, oCmdRow, oCmdCol, oCmdSize};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mk(input logic v, input logic [7:0] col, input logic [1:0] los, input logic [1:0] sz);
    return {11'b0, sz, los, col, v};
  endfunction

  function automatic logic [31:0] key(input ev_t e, input bit rowcmd);
    return rowcmd ? {8'b0, e.cmd, e.row, 10'b0} : {8'b0, e.cmd, 11'b0, e.col, e.size};
  endfunction

  function automatic int cyc_at(input int i);
    return (i >= 0 && i < log_cyc.size()) ? log_cyc[i] : -1000;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic add(input logic [2:0] cmd, input logic [10:0] row, input logic [7:0] col, input logic [1:0] sz);
    exp_q.push_back({cmd, row, col, sz});
  endtask

  task automatic begin_test();
    log_q.delete();
    log_cyc.delete();
    exp_q.delete();
  endtask

  task automatic cmp_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      bit  rc = (exp_q[i].cmd == CMD_ACT) || (exp_q[i].cmd == CMD_PRE);
      ev_t o  = (i < log_q.size()) ? log_q[i] : '1;
      check($sformatf("%s_%0d", tag, i), key(o, rc), key(exp_q[i], rc));
    end
  endtask

  task automatic start_row(input logic [10:0] row, output int r);
    nxt();
    iRowReq = 1'b1;
    iRow    = row;
    smp();
    check("row_ack", oRowAck, 1'b1);
    nxt();
    iRowReq = 1'b0;
    smp();
    r = cyc;
    check("rob_rd", {oROB_Rd, oROB_Row}, {1'b1, row});
  endtask

  task automatic drive_item(input logic [23:0] it, input logic e);
    nxt();
    iROB_ItemValid = 1'b1;
    iROB_Item      = it;
    iROB_ItemEnd   = e;
  endtask

  task automatic clear_items();
    nxt();
    iROB_ItemValid = 1'b0;
    iROB_Item      = '0;
    iROB_ItemEnd   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit toggle, output int t);
    bit done = 1'b0;
    t = -1;
    for (int i = 0; i < budget && !done; i++) begin
      smp();
      if (!oBusy) begin
        done = 1'b1;
        t    = cyc;
      end else begin
        nxt();
        if (toggle) iCmdReady = ~iCmdReady;
      end
    end
    check("idle_reached", done, 1'b1);
    iCmdReady = 1'b1;
  endtask

  initial begin
    int r;
    int t;
    int ncol;
    resetn = 1'b0;
    iRowReq = 1'b0;
    iRow = '0;
    iROB_ItemValid = 1'b0;
    iROB_Item = '0;
    iROB_ItemEnd = 1'b0;
    iCmdReady = 1'b1;

    // Reset state
    repeat (3) smp();
    check("rst_outs", {oRowAck, oROB_Rd, oROB_Row, oCmdValid, oCmd, oCmdRow, oCmdCol, oCmdSize},
          31'h0);
    check("rst_flags", {oBusy, oOverflow, oTimeout}, 3'b000);
    nxt();
    resetn = 1'b1;

    // Three loads on row 0x05A
    begin_test();
    start_row(11'h05A, r);
    drive_item(mk(1'b1, 8'h04, LOS_LOAD, 2'd0), 1'b0);
    drive_item(mk(1'b1, 8'h08, LOS_LOAD, 2'd0), 1'b0);
    drive_item(mk(1'b1, 8'h0C, LOS_LOAD, 2'd0), 1'b1);
    clear_items();
    wait_idle(40, 1'b0, t);
    add(CMD_ACT, 11'h05A, 8'h00, 2'd0);
    add(CMD_RD, 11'h000, 8'h04, 2'd0);
    add(CMD_RD, 11'h000, 8'h08, 2'd0);
    add(AUTO ? CMD_RDA : CMD_RD, 11'h000, 8'h0C, 2'd0);
    if (!AUTO) add(CMD_PRE, 11'h05A, 8'h00, 2'd0);
    cmp_log("t1");
    check("t1_act_cycle", cyc_at(0), r + 2);
    check("t1_trcd_gap", cyc_at(1) - cyc_at(0), 4);
    check("t1_trp_gap", t - cyc_at(log_cyc.size() - 1), 4);

    // Mixed loads/stores with a LoS=00 item and a toggling ready
    begin_test();
    n_stall = 0;
    start_row(11'h155, r);
    drive_item(mk(1'b1, 8'h10, LOS_LOAD, 2'd1), 1'b0);
    drive_item(mk(1'b1, 8'h30, 2'b00, 2'd0), 1'b0);
    drive_item(mk(1'b1, 8'h20, LOS_STORE, 2'd2), 1'b0);
    drive_item(mk(1'b1, 8'h40, LOS_STORE, 2'd3), 1'b1);
    clear_items();
    wait_idle(60, 1'b1, t);
    add(CMD_ACT, 11'h155, 8'h00, 2'd0);
    add(CMD_RD, 11'h000, 8'h10, 2'd1);
    add(CMD_WR, 11'h000, 8'h20, 2'd2);
    add(AUTO ? CMD_WRA : CMD_WR, 11'h000, 8'h40, 2'd3);
    if (!AUTO) add(CMD_PRE, 11'h155, 8'h00, 2'd0);
    cmp_log("t2");
    check("t2_stalled", n_stall != 0, 1'b1);

    // End alone: no DRAM commands
    begin_test();
    any_valid = 1'b0;
    start_row(11'h123, r);
    nxt();
    iROB_ItemEnd = 1'b1;
    clear_items();
    wait_idle(10, 1'b0, t);
    check("t3_idle_cycle", t, r + 3);
    check("t3_no_valid", any_valid, 1'b0);
    check("t3_log_len", log_q.size(), 0);

    // Nine loads into a stalled controller
    begin_test();
    iCmdReady = 1'b0;
    start_row(11'h200, r);
    for (int i = 1; i <= 8; i++) drive_item(mk(1'b1, 8'(i), LOS_LOAD, 2'd0), 1'b0);
    smp();
    check("t4_ovf_before", oOverflow, 1'b0);
    drive_item(mk(1'b1, 8'h09, LOS_LOAD, 2'd0), 1'b1);
    clear_items();
    iCmdReady = 1'b1;
    smp();
    check("t4_ovf_after", oOverflow, 1'b1);
    wait_idle(60, 1'b0, t);
    add(CMD_ACT, 11'h200, 8'h00, 2'd0);
    for (int i = 1; i <= 7; i++) add(CMD_RD, 11'h000, 8'(i), 2'd0);
    add(AUTO ? CMD_RDA : CMD_RD, 11'h000, 8'h08, 2'd0);
    if (!AUTO) add(CMD_PRE, 11'h200, 8'h00, 2'd0);
    cmp_log("t4");
    ncol = 0;
    foreach (log_q[i]) if (log_q[i].cmd != CMD_ACT && log_q[i].cmd != CMD_PRE) ncol++;
    check("t4_col_count", ncol, 8);

    // Two items and no end: timeout closes the stream
    begin_test();
    start_row(11'h0F0, r);
    drive_item(mk(1'b1, 8'h11, LOS_STORE, 2'd0), 1'b0);
    drive_item(mk(1'b1, 8'h22, LOS_LOAD, 2'd1), 1'b0);
    clear_items();
    while (cyc < r + 15) nxt();
    smp();
    check("t5_tmo_before", oTimeout, 1'b0);
    nxt();
    smp();
    check("t5_tmo_after", oTimeout, 1'b1);
    wait_idle(40, 1'b0, t);
    add(CMD_ACT, 11'h0F0, 8'h00, 2'd0);
    add(CMD_WR, 11'h000, 8'h11, 2'd0);
    add(CMD_RD, 11'h000, 8'h22, 2'd1);
    add(CMD_PRE, 11'h0F0, 8'h00, 2'd0);
    cmp_log("t5");
    check("t5_ovf_sticky", oOverflow, 1'b1);

    // Two stores, then reset during TRCD
    begin_test();
    start_row(11'h0AA, r);
    drive_item(mk(1'b1, 8'h31, LOS_STORE, 2'd2), 1'b0);
    drive_item(mk(1'b1, 8'h32, LOS_STORE, 2'd2), 1'b1);
    clear_items();
    wait_idle(40, 1'b0, t);
    add(CMD_ACT, 11'h0AA, 8'h00, 2'd0);
    add(CMD_WR, 11'h000, 8'h31, 2'd2);
    add(AUTO ? CMD_WRA : CMD_WR, 11'h000, 8'h32, 2'd2);
    if (!AUTO) add(CMD_PRE, 11'h0AA, 8'h00, 2'd0);
    cmp_log("t6");

    start_row(11'h077, r);
    drive_item(mk(1'b1, 8'h01, LOS_STORE, 2'd0), 1'b1);
    clear_items();
    smp();
    check("t6_act", {oCmdValid, oCmd, oCmdRow}, {1'b1, CMD_ACT, 11'h077});
    check("t6_sticky", {oOverflow, oTimeout}, 2'b11);
    nxt();
    resetn = 1'b0;
    smp();
    check("t6_rst_outs", {oRowAck, oROB_Rd, oROB_Row, oCmdValid, oCmd, oCmdRow, oCmdCol, oCmdSize},
          31'h0);
    check("t6_rst_flags", {oBusy, oOverflow, oTimeout}, 3'b000);
    nxt();
    resetn = 1'b1;
    nxt();
    smp();
    check("t6_post_idle", {oBusy, oCmdValid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
